wino_tile_scheduler: RTL

- Frame-level sequencer for the 4x4 Winograd F(2x2,3x3) input transform.
- Walks an unsigned 8-bit feature map stored in a 16-bit-word buffer and fetches overlapping 4x4 tiles (stride 2) through a single-cycle-latency read port.
- Assembles each tile into the 128-bit packed layout the combinational input transform consumes, and holds it under a valid/ready handshake.
- Tile fetch overlaps with downstream consumption of the previous tile (one fetch buffer plus one output register).

---
 rtl/wino_tile_scheduler_if.sv | 32 +++
 rtl/wino_tile_scheduler.sv | 130 +++++++++++++
 2 files changed

// File: rtl/wino_tile_scheduler_if.sv
// Frame control, buffer read port and tile output handshake of the Winograd tile scheduler.
// The scheduler uses the master modport; the frame controller, buffer and consumer sit on slave.
interface wino_tile_scheduler_if #(
   parameter int AW = 10
) ();
   logic          start;
   logic [AW-1:0] base_addr;
   logic          busy;
   logic          done;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [15:0]   rd_data;
   logic [127:0]  tile_data;
   logic          tile_valid;
   logic          tile_ready;
   logic [7:0]    tile_x;
   logic [7:0]    tile_y;
   logic          tile_first;
   logic          tile_last;

   modport master (
      input  start, base_addr, rd_data, tile_ready,
      output busy, done, rd_en, rd_addr, tile_data, tile_valid,
             tile_x, tile_y, tile_first, tile_last
   );

   modport slave (
      output start, base_addr, rd_data, tile_ready,
      input  busy, done, rd_en, rd_addr, tile_data, tile_valid,
             tile_x, tile_y, tile_first, tile_last
   );
endinterface

// File: rtl/wino_tile_scheduler.sv
// Fetches overlapping 4x4 stride-2 tiles of an 8-bit feature map for the F(2x2,3x3) input transform.
// One fetch buffer plus one output register lets the next fetch overlap consumption of the current tile.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing the 8 word reads of the current tile
// DRAIN | last read word returns and is captured
// HOLD  | tile complete, waiting for the output register to free up
// FLUSH | last tile loaded, waiting for its handshake before done
module wino_tile_scheduler #(
   parameter int IMG_W = 32,
   parameter int IMG_H = 32,
   parameter int AW    = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   wino_tile_scheduler_if.master  bus
);
   localparam int TX     = IMG_W / 2 - 1;
   localparam int TY     = IMG_H / 2 - 1;
   localparam int HALF_W = IMG_W / 2;

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, HOLD, FLUSH} state_t;

   state_t        state_q;
   logic [AW-1:0] base_q;
   logic [7:0]    tx_q, ty_q;
   logic [2:0]    rd_cnt_q, slot_q;
   logic          cap_q;
   logic [127:0]  fbuf_q;
   logic [127:0]  tile_data_q;
   logic          tile_valid_q;
   logic [7:0]    tile_x_q, tile_y_q;
   logic          tile_first_q, tile_last_q;
   logic          done_q;

   logic [AW-1:0] row_d, rd_addr_d;
   logic          last_d, free_d;

   always_comb begin
      row_d     = AW'({ty_q, 1'b0}) + AW'(rd_cnt_q[2:1]);
      rd_addr_d = base_q + row_d * AW'(HALF_W) + AW'(tx_q) + AW'(rd_cnt_q[0]);
      last_d    = (tx_q == 8'(TX - 1)) && (ty_q == 8'(TY - 1));
      free_d    = !tile_valid_q || bus.tile_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         base_q       <= '0;
         tx_q         <= '0;
         ty_q         <= '0;
         rd_cnt_q     <= '0;
         slot_q       <= '0;
         cap_q        <= 1'b0;
         fbuf_q       <= '0;
         tile_data_q  <= '0;
         tile_valid_q <= 1'b0;
         tile_x_q     <= '0;
         tile_y_q     <= '0;
         tile_first_q <= 1'b0;
         tile_last_q  <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         cap_q  <= (state_q == FETCH);
         slot_q <= rd_cnt_q;
         // Read k carries pixel bytes 2k and 2k+1 of the tile.
         if (cap_q) fbuf_q[16*slot_q +: 16] <= bus.rd_data;
         if (tile_valid_q && bus.tile_ready) tile_valid_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  base_q   <= bus.base_addr;
                  tx_q     <= '0;
                  ty_q     <= '0;
                  rd_cnt_q <= '0;
                  state_q  <= FETCH;
               end
            end
            FETCH: begin
               rd_cnt_q <= rd_cnt_q + 3'd1;
               if (rd_cnt_q == 3'd7) state_q <= DRAIN;
            end
            DRAIN: state_q <= HOLD;
            HOLD: begin
               if (free_d) begin
                  tile_data_q  <= fbuf_q;
                  tile_valid_q <= 1'b1;
                  tile_x_q     <= tx_q;
                  tile_y_q     <= ty_q;
                  tile_first_q <= (tx_q == 8'd0) && (ty_q == 8'd0);
                  tile_last_q  <= last_d;
                  if (last_d) begin
                     state_q <= FLUSH;
                  end else begin
                     if (tx_q == 8'(TX - 1)) begin
                        tx_q <= '0;
                        ty_q <= ty_q + 8'd1;
                     end else begin
                        tx_q <= tx_q + 8'd1;
                     end
                     rd_cnt_q <= '0;
                     state_q  <= FETCH;
                  end
               end
            end
            FLUSH: begin
               if (tile_valid_q && bus.tile_ready) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = done_q;
   assign bus.rd_en      = (state_q == FETCH);
   assign bus.rd_addr    = rd_addr_d;
   assign bus.tile_data  = tile_data_q;
   assign bus.tile_valid = tile_valid_q;
   assign bus.tile_x     = tile_x_q;
   assign bus.tile_y     = tile_y_q;
   assign bus.tile_first = tile_first_q;
   assign bus.tile_last  = tile_last_q;
endmodule
